// File: rtl/irq_pulse_gen_if.sv
// Bus bundle for irq_pulse_gen: per-channel config writes, start/stop
// controls and the pulse/status outputs.
interface irq_pulse_gen_if #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16,
    parameter int REP_W    = 8,
    parameter int CH_W     = 2
);
    logic                cfg_we;
    logic [CH_W-1:0]     cfg_ch;
    logic [CNT_W-1:0]    cfg_delay;
    logic [CNT_W-1:0]    cfg_width;
    logic [CNT_W-1:0]    cfg_period;
    logic [REP_W-1:0]    cfg_repeat;
    logic [CHANNELS-1:0] start;
    logic [CHANNELS-1:0] stop;
    logic [CHANNELS-1:0] irq_ch;
    logic                IRQ;
    logic [CHANNELS-1:0] busy;
    logic [CHANNELS-1:0] done;

    modport master (
        output cfg_we, cfg_ch, cfg_delay, cfg_width, cfg_period, cfg_repeat,
        output start, stop,
        input  irq_ch, IRQ, busy, done
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_delay, cfg_width, cfg_period, cfg_repeat,
        input  start, stop,
        output irq_ch, IRQ, busy, done
    );
endinterface

// File: rtl/irq_pulse_gen.sv
// Multi-channel programmable interrupt pulse generator: each channel produces
// delay / width / period / repeat pulse trains, all ORed onto one IRQ line.
module irq_pulse_gen #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16,
    parameter int REP_W    = 8,
    parameter int CH_W     = 2
) (
    input  logic          clk,
    input  logic          reset,
    irq_pulse_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DELAY, HIGH, LOW} state_t;

    logic [CHANNELS-1:0] irq_vec;
    logic [CHANNELS-1:0] busy_vec;
    logic [CHANNELS-1:0] done_vec;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [CNT_W-1:0] sh_delay_reg, sh_width_reg, sh_period_reg;
            logic [REP_W-1:0] sh_repeat_reg;
            state_t           state_reg, state_next;
            logic [CNT_W-1:0] cnt_reg, cnt_next;
            logic [CNT_W-1:0] wid_m1_reg, wid_m1_next;
            logic [CNT_W-1:0] low_m1_reg, low_m1_next;
            logic [REP_W-1:0] rem_reg, rem_next;
            logic             inf_reg, inf_next;
            logic             irq_reg;
            logic             done_reg, done_next;
            logic             cfg_hit;
            logic [CNT_W-1:0] eff_width;
            logic [CNT_W:0]   min_period, eff_period;
            logic [CNT_W-1:0] start_wid_m1, start_low_m1;

            // Channel indices beyond CHANNELS never match, so such writes drop.
            assign cfg_hit = bus.cfg_we && (bus.cfg_ch == CH_W'(gi));

            always_ff @(posedge clk) begin
                if (reset) begin
                    sh_delay_reg  <= '0;
                    sh_width_reg  <= CNT_W'(1);
                    sh_period_reg <= CNT_W'(2);
                    sh_repeat_reg <= REP_W'(1);
                end else if (cfg_hit) begin
                    sh_delay_reg  <= bus.cfg_delay;
                    sh_width_reg  <= bus.cfg_width;
                    sh_period_reg <= bus.cfg_period;
                    sh_repeat_reg <= bus.cfg_repeat;
                end
            end

            // Period is widened by one bit so width = max never wraps.
            assign eff_width    = (sh_width_reg == '0) ? CNT_W'(1) : sh_width_reg;
            assign min_period   = {1'b0, eff_width} + (CNT_W+1)'(1);
            assign eff_period   = ({1'b0, sh_period_reg} < min_period) ? min_period
                                                                       : {1'b0, sh_period_reg};
            assign start_wid_m1 = eff_width - CNT_W'(1);
            assign start_low_m1 = CNT_W'(eff_period - {1'b0, eff_width} - (CNT_W+1)'(1));

            always_comb begin
                state_next  = state_reg;
                cnt_next    = cnt_reg;
                wid_m1_next = wid_m1_reg;
                low_m1_next = low_m1_reg;
                rem_next    = rem_reg;
                inf_next    = inf_reg;
                done_next   = 1'b0;
                if (bus.stop[gi]) begin
                    state_next = IDLE;
                end else begin
                    case (state_reg)
                        IDLE: begin
                            if (bus.start[gi]) begin
                                wid_m1_next = start_wid_m1;
                                low_m1_next = start_low_m1;
                                rem_next    = sh_repeat_reg;
                                inf_next    = (sh_repeat_reg == '0);
                                if (sh_delay_reg != '0) begin
                                    state_next = DELAY;
                                    cnt_next   = sh_delay_reg - CNT_W'(1);
                                end else begin
                                    state_next = HIGH;
                                    cnt_next   = start_wid_m1;
                                end
                            end
                        end
                        DELAY: begin
                            if (cnt_reg == '0) begin
                                state_next = HIGH;
                                cnt_next   = wid_m1_reg;
                            end else begin
                                cnt_next = cnt_reg - CNT_W'(1);
                            end
                        end
                        HIGH: begin
                            if (cnt_reg == '0) begin
                                if (!inf_reg && rem_reg == REP_W'(1)) begin
                                    state_next = IDLE;
                                    done_next  = 1'b1;
                                end else begin
                                    state_next = LOW;
                                    cnt_next   = low_m1_reg;
                                end
                            end else begin
                                cnt_next = cnt_reg - CNT_W'(1);
                            end
                        end
                        LOW: begin
                            if (cnt_reg == '0) begin
                                state_next = HIGH;
                                cnt_next   = wid_m1_reg;
                                if (!inf_reg) begin
                                    rem_next = rem_reg - REP_W'(1);
                                end
                            end else begin
                                cnt_next = cnt_reg - CNT_W'(1);
                            end
                        end
                        default: state_next = IDLE;
                    endcase
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_reg  <= IDLE;
                    cnt_reg    <= '0;
                    wid_m1_reg <= '0;
                    low_m1_reg <= '0;
                    rem_reg    <= '0;
                    inf_reg    <= 1'b0;
                    irq_reg    <= 1'b0;
                    done_reg   <= 1'b0;
                end else begin
                    state_reg  <= state_next;
                    cnt_reg    <= cnt_next;
                    wid_m1_reg <= wid_m1_next;
                    low_m1_reg <= low_m1_next;
                    rem_reg    <= rem_next;
                    inf_reg    <= inf_next;
                    irq_reg    <= (state_next == HIGH);
                    done_reg   <= done_next;
                end
            end

            assign irq_vec[gi]  = irq_reg;
            assign busy_vec[gi] = (state_reg != IDLE);
            assign done_vec[gi] = done_reg;
        end
    endgenerate

    assign bus.irq_ch = irq_vec;
    assign bus.IRQ    = |irq_vec;
    assign bus.busy   = busy_vec;
    assign bus.done   = done_vec;
endmodule

// File: tb/tb_irq_pulse_gen.sv
// Directed bench for irq_pulse_gen; cycle numbers in the scenarios are relative
// to a per-scenario origin and inputs are driven 1 time unit after each edge.
module tb_irq_pulse_gen;
    localparam int CHANNELS = 4;
    localparam int CNT_W    = 16;
    localparam int REP_W    = 8;
    localparam int CH_W     = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   t       = 0;
    int   n_assert = 0;
    int   n_fail   = 0;

    irq_pulse_gen_if #(.CHANNELS(CHANNELS), .CNT_W(CNT_W), .REP_W(REP_W), .CH_W(CH_W)) bus ();

    irq_pulse_gen #(.CHANNELS(CHANNELS), .CNT_W(CNT_W), .REP_W(REP_W), .CH_W(CH_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic chk1(input string tag, input int c, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, c, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input int c, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, c, obs, exp);
        end
    endtask

    task automatic set_cfg(input int ch, input int d, input int w, input int p, input int r);
        bus.cfg_ch     = CH_W'(ch);
        bus.cfg_delay  = CNT_W'(d);
        bus.cfg_width  = CNT_W'(w);
        bus.cfg_period = CNT_W'(p);
        bus.cfg_repeat = REP_W'(r);
    endtask

    task automatic cfg_write(input int ch, input int d, input int w, input int p, input int r);
        set_cfg(ch, d, w, p, r);
        bus.cfg_we = 1'b1;
        tick();
        bus.cfg_we = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk4({tag, "_irq_ch"}, t, bus.irq_ch, 4'b0000);
        chk4({tag, "_busy"},   t, bus.busy,   4'b0000);
        chk4({tag, "_done"},   t, bus.done,   4'b0000);
        chk1({tag, "_IRQ"},    t, bus.IRQ,    1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        chk_all_zero("rst");
        reset = 1'b0;
        t = 0;
    endtask

    initial begin
        bus.cfg_we = 1'b0;
        set_cfg(0, 0, 0, 0, 0);
        bus.start = '0;
        bus.stop  = '0;

        // ch0 d3 w2 p5 r3 and ch1 d5 w1 p3 r2, both started in cycle 10
        do_reset();
        cfg_write(0, 3, 2, 5, 3);
        cfg_write(1, 5, 1, 3, 2);
        while (t < 10) tick();
        bus.start = 4'b0011;
        tick();
        bus.start = '0;
        for (int c = 11; c <= 27; c++) begin
            logic e0, e1;
            e0 = (c inside {[14:15], [19:20], [24:25]});
            e1 = (c inside {16, 19});
            chk1("a_irq0",  c, bus.irq_ch[0], e0);
            chk1("a_irq1",  c, bus.irq_ch[1], e1);
            chk1("a_IRQ",   c, bus.IRQ, e0 | e1);
            chk1("a_busy0", c, bus.busy[0], (c >= 11 && c <= 25));
            chk1("a_busy1", c, bus.busy[1], (c >= 11 && c <= 19));
            chk1("a_done0", c, bus.done[0], (c == 26));
            chk1("a_done1", c, bus.done[1], (c == 20));
            tick();
        end
        $display("scenario A: ch0/ch1 repeat trains, done at 26/20");

        // ch2 infinite train stopped in cycle 21; ch3 width=0/period=1 clamping
        do_reset();
        cfg_write(2, 0, 1, 10, 0);
        cfg_write(3, 0, 0, 1, 2);
        t = 0;
        for (int c = 0; c <= 24; c++) begin
            logic e2, e3;
            e2 = (c inside {1, 11, 21});
            e3 = (c inside {6, 8});
            chk1("b_irq2",  c, bus.irq_ch[2], e2);
            chk1("b_irq3",  c, bus.irq_ch[3], e3);
            chk1("b_IRQ",   c, bus.IRQ, e2 | e3);
            chk1("b_busy2", c, bus.busy[2], (c >= 1 && c <= 21));
            chk1("b_busy3", c, bus.busy[3], (c >= 6 && c <= 8));
            chk1("b_done2", c, bus.done[2], 1'b0);
            chk1("b_done3", c, bus.done[3], (c == 9));
            bus.start = (c == 0) ? 4'b0100 : (c == 5) ? 4'b1000 : 4'b0000;
            bus.stop  = (c == 21) ? 4'b0100 : 4'b0000;
            tick();
        end
        bus.start = '0;
        bus.stop  = '0;
        $display("scenario B: ch2 stop at 21, ch3 effective width/period");

        // ch0 repeat=0 hit by reset mid-pulse, then a bare start uses defaults
        do_reset();
        cfg_write(0, 0, 2, 4, 0);
        t = 0;
        for (int c = 0; c <= 5; c++) begin
            chk1("d_irq0", c, bus.irq_ch[0], (c inside {1, 2, 5}));
            bus.start = (c == 0) ? 4'b0001 : 4'b0000;
            reset     = (c == 5);
            tick();
        end
        chk_all_zero("d_midrst");
        reset = 1'b0;
        while (t < 8) tick();
        bus.start = 4'b0001;
        tick();
        bus.start = '0;
        for (int c = 9; c <= 12; c++) begin
            chk1("d_irq0",  c, bus.irq_ch[0], (c == 9));
            chk1("d_busy0", c, bus.busy[0],   (c == 9));
            chk1("d_done0", c, bus.done[0],   (c == 10));
            tick();
        end
        $display("scenario D: reset mid-pulse, default config single pulse");

        // retrigger ignored while busy; config written at start uses old values
        cfg_write(0, 2, 1, 3, 2);
        t = 0;
        for (int c = 0; c <= 18; c++) begin
            chk1("e_irq0",  c, bus.irq_ch[0], (c inside {3, 6, 16}));
            chk1("e_busy0", c, bus.busy[0],   ((c >= 1 && c <= 6) || (c >= 9 && c <= 16)));
            chk1("e_done0", c, bus.done[0],   (c inside {7, 17}));
            bus.start  = (c inside {0, 3, 8}) ? 4'b0001 : 4'b0000;
            bus.cfg_we = (c inside {3, 8});
            if (c == 3) set_cfg(0, 7, 1, 3, 1);
            if (c == 8) set_cfg(0, 1, 1, 3, 1);
            tick();
        end
        bus.start  = '0;
        bus.cfg_we = 1'b0;
        $display("scenario E: no retrigger, delayed config takes effect on next start");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/irq_pulse_gen.md
Name: irq_pulse_gen

Overview:
- Parametrised, synthesizable multi-channel interrupt pulse generator. It replaces hand-timed IRQ pulse sequences in CPU-level benches.
- Each channel runs its own programmable FSM: start delay, pulse width, period and repeat count.
- Channels combine into a single IRQ line that drives the CPU's IRQ input. The per-channel lines are also exposed for multi-source interrupt work.

Parameters:
- CHANNELS, 4, number of independent pulse channels (1..16).
- CNT_W, 16, width of delay/width/period counters.
- REP_W, 8, width of repeat count.
- CH_W, 2, width of channel select (set to ceil(log2(CHANNELS)), minimum 1).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- cfg_we  in  1  write config for channel cfg_ch.
- cfg_ch  in  CH_W  channel select for cfg_we.
- cfg_delay  in  CNT_W  cycles from start to first pulse.
- cfg_width  in  CNT_W  pulse high time in cycles.
- cfg_period  in  CNT_W  rising-edge-to-rising-edge spacing.
- cfg_repeat  in  REP_W  pulse count; 0 = infinite.
- start  in  CHANNELS  per-channel start request.
- stop  in  CHANNELS  per-channel abort.
- irq_ch  out  CHANNELS  per-channel pulse output (registered).
- IRQ  out  1  OR of irq_ch.
- busy  out  CHANNELS  channel not IDLE.
- done  out  CHANNELS  one-cycle pulse on natural completion.

Behaviour:
- Cycle numbering: "cycle n" is the period following rising edge n. An input "in cycle s" is sampled at the end of cycle s.

Reset:
- All channels go to IDLE. irq_ch, IRQ, busy and done are all 0 in the cycle after reset is sampled.
- Config registers reset to delay=0, width=1, period=2, repeat=1.
- Reset mid-pulse drops irq_ch on the next edge. No done pulse is produced.

Config:
- cfg_we writes the four shadow registers of channel cfg_ch. Writes with cfg_ch >= CHANNELS are ignored.
- Config is latched into working registers only at start. Writes while a channel is busy affect only its next start.
- If cfg_we and start hit the same channel in the same cycle, the start uses the previous config.

Effective values:
- eff_width = max(cfg_width, 1).
- eff_period = max(cfg_period, eff_width + 1), so there is always at least one low cycle.

Per-channel FSM (IDLE, DELAY, HIGH, LOW):
- IDLE, start[i] in cycle s:
  - If D > 0: go to DELAY with the counter loaded to D-1.
  - If D = 0: go directly to HIGH.
  - Either way, the first high cycle is s+1+D and busy is high from cycle s+1.
- DELAY: the counter decrements each cycle. When it reaches 0, go to HIGH with the counter loaded to eff_width-1.
- HIGH: irq_ch[i]=1. When the counter reaches 0, check the remaining-pulse count (R, or infinite when R=0):
  - If this was the last pulse: go to IDLE, with done[i]=1 in the following cycle.
  - Otherwise: go to LOW with the counter loaded to eff_period-eff_width-1.
- LOW: irq_ch[i]=0. When the counter reaches 0, go to HIGH, reload the width and decrement the remaining count.

Control events:
- stop[i] in any state: go to IDLE on the next edge, with irq_ch low and no done. Stop beats a simultaneous start.
- start[i] while busy[i] is ignored; there is no retrigger.
- With repeat=0 the channel runs until stop or reset.

Outputs:
- IRQ is a combinational OR of the registered irq_ch, adding no extra latency.
- Channels are fully independent. Simultaneous starts on several channels are all accepted.

Test Plan:
- ch0 delay=3, width=2, period=5, repeat=3, start in cycle 10 -> irq_ch[0]=1 in cycles 14-15, 19-20 and 24-25; busy[0] is 1 in cycles 11-25; done[0]=1 only in cycle 26; IRQ mirrors irq_ch[0].
- ch0 as above plus ch1 delay=5, width=1, period=3, repeat=2, both started in cycle 10 -> irq_ch[1]=1 in cycles 16 and 19; IRQ=1 in cycles 14-16, 19-20 and 24-25.
- ch2 delay=0, width=1, period=10, repeat=0, start in cycle 0, stop in cycle 21 -> highs at cycles 1, 11 and 21; irq_ch[2]=0 and busy[2]=0 from cycle 22; done never asserts.
- ch3 width=0, period=1, repeat=2, delay=0, start in cycle 5 -> highs at cycles 6 and 8; low in cycle 7; done in cycle 9.
- ch0 repeat=0 running, reset asserted during a high cycle -> all outputs 0 next cycle; after reset, a bare start in cycle s gives a single one-cycle pulse in cycle s+1 (the default config).
- ch0 busy, start re-pulsed and cfg_we with delay=7 in the same cycle -> the running sequence is unchanged; the next start after done uses delay=7.
